// File: rtl/jpeg_line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// jpeg_line_buffer_ctrl
//
// Ping-pong strip controller for the 64-bit x 2880-word dual-port EBR line
// buffer of the JPEG encoder. The write side fills one 8-line bank with
// raster-order pixel words. The read side drains the other bank in 8x8-block
// column order towards the DCT. Each bank runs its own
// EMPTY -> FILLING -> FULL -> DRAINING life cycle. Because of that cycle, the
// writer and the reader never own the same bank at the same time.
//
// Optional feature (macro LB_FLUSH_EN):
//   Adds the flush_i pulse. A FILLING bank holding k complete lines
//   (1 <= k < 8) is closed at once. The reader then repeats line k-1 for
//   rows k..7, which gives bottom edge padding. Any partial line is dropped.
//   When the macro is undefined, a bank closes only after STRIP_LINES lines.
//
// Ports
//   clk, resetn         single clock (EBR clocks tie to it), async active-low reset
//   frame_start_i       latches cfg_wpl_i, clears pointers; only when both banks EMPTY
//   cfg_wpl_i   [7:0]   words per line (0 -> 1, clamped to MAX_WPL)
//   flush_i             (LB_FLUSH_EN only) close the filling bank early
//   in_valid_i/in_ready_o/in_data_i[63:0]       raster pixel words, byte 0 leftmost
//   out_valid_o/out_ready_i/out_data_o[63:0]    block-column-order words to DCT
//   out_row_last_o      word is row 7 of its 8x8 block
//   out_strip_last_o    word is the final word of the bank
//   ram_wr_en_o, ram_ben_o[7:0], ram_wr_addr_o[11:0], ram_wr_data_o[63:0]
//   ram_rd_en_o, ram_rd_addr_o[11:0], ram_rd_data_i[63:0] (1-cycle latency)
//   bank_full_o [1:0]   per-bank FULL/DRAINING status
// -----------------------------------------------------------------------------
module jpeg_line_buffer_ctrl #(
  parameter int BANK_WORDS  = 1440,
  parameter int STRIP_LINES = 8,
  parameter int MAX_WPL     = 180
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_start_i,
  input  logic [7:0]  cfg_wpl_i,
`ifdef LB_FLUSH_EN
  input  logic        flush_i,
`endif
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_data_o,
  output logic        out_row_last_o,
  output logic        out_strip_last_o,
  output logic        ram_wr_en_o,
  output logic [7:0]  ram_ben_o,
  output logic [11:0] ram_wr_addr_o,
  output logic [63:0] ram_wr_data_o,
  output logic        ram_rd_en_o,
  output logic [11:0] ram_rd_addr_o,
  input  logic [63:0] ram_rd_data_i,
  output logic [1:0]  bank_full_o
);

  localparam int RW = $clog2(STRIP_LINES);      // row / line index width
  localparam int LW = $clog2(STRIP_LINES + 1);  // line count width (1..8)
  localparam logic [11:0] BANK1_BASE = 12'(BANK_WORDS);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  function automatic logic [11:0] bank_base(input logic b);
    return b ? BANK1_BASE : 12'd0;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  bank_state_e       bank_state_q [2];
  logic [LW-1:0]     bank_lines_q [2];   // valid lines held by each bank
  logic              cfg_valid_q;
  logic [7:0]        wpl_q;
  logic              wr_bank_q, rd_bank_q;

  logic [7:0]        wr_col_q;
  logic [RW-1:0]     wr_line_q;
  logic [11:0]       wr_addr_q;

  logic [7:0]        rd_col_q;
  logic [RW-1:0]     rd_row_q;
  logic [11:0]       rd_addr_q;          // address of the next word to issue
  logic [11:0]       rd_col_addr_q;      // base + current column
  logic [LW-1:0]     rd_lines_q;
  logic              rd_issue_done_q;

  logic              inflight_q, inflight_rl_q, inflight_sl_q;
  logic [63:0]       fifo_data_q [2];
  logic              fifo_rl_q   [2];
  logic              fifo_sl_q   [2];
  logic              fifo_wr_ptr_q, fifo_rd_ptr_q;
  logic [1:0]        fifo_cnt_q;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic [7:0] cfg_wpl_eff;
  logic       frame_ok, flush_req, flush_hit;
  logic       wr_fire, wr_line_end, wr_strip_end;
  logic       pop, rd_active, rd_row_last, rd_strip_last, rd_row_step;
  logic [1:0] occ;

  assign cfg_wpl_eff = (cfg_wpl_i == 8'd0)          ? 8'd1 :
                       (cfg_wpl_i > 8'(MAX_WPL))    ? 8'(MAX_WPL) : cfg_wpl_i;

  assign frame_ok = frame_start_i &&
                    (bank_state_q[0] == BANK_EMPTY) && (bank_state_q[1] == BANK_EMPTY);

`ifdef LB_FLUSH_EN
  assign flush_req = flush_i;
`else
  assign flush_req = 1'b0;
`endif

  // A flush with no complete line leaves the bank filling.
  assign flush_hit = flush_req && (bank_state_q[wr_bank_q] == BANK_FILLING) &&
                     (wr_line_q != '0);

  // Input is held off during the cycle when frame_start or flush changes the
  // pointers, so that no word can land on a stale address.
  assign in_ready_o = cfg_valid_q && !frame_ok && !flush_req &&
                      ((bank_state_q[wr_bank_q] == BANK_EMPTY) ||
                       (bank_state_q[wr_bank_q] == BANK_FILLING));

  assign wr_fire      = in_valid_i && in_ready_o;
  assign wr_line_end  = (wr_col_q == wpl_q - 8'd1);
  assign wr_strip_end = wr_line_end && (wr_line_q == RW'(STRIP_LINES - 1));

  assign out_valid_o = (fifo_cnt_q != 2'd0);
  assign pop         = out_valid_o && out_ready_i;

  // Count the FIFO slot that frees up this cycle. Without it, the reader would
  // stall every other cycle while the sink takes a word per clock.
  assign occ         = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign rd_active   = (bank_state_q[rd_bank_q] == BANK_DRAINING) && !rd_issue_done_q;
  assign ram_rd_en_o = rd_active && (occ < 2'd2);

  assign rd_row_last   = (rd_row_q == RW'(STRIP_LINES - 1));
  assign rd_strip_last = rd_row_last && (rd_col_q == wpl_q - 8'd1);
  // Rows past the last valid line hold the address, which replicates that line.
  assign rd_row_step   = (LW'(rd_row_q) + LW'(1)) < rd_lines_q;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ram_wr_en_o      = wr_fire;
  assign ram_ben_o        = 8'hFF;
  assign ram_wr_addr_o    = wr_addr_q;
  assign ram_wr_data_o    = wr_fire ? in_data_i : 64'd0;
  assign ram_rd_addr_o    = rd_addr_q;
  assign out_data_o       = out_valid_o ? fifo_data_q[fifo_rd_ptr_q] : 64'd0;
  assign out_row_last_o   = out_valid_o && fifo_rl_q[fifo_rd_ptr_q];
  assign out_strip_last_o = out_valid_o && fifo_sl_q[fifo_rd_ptr_q];

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_full_o[b] = (bank_state_q[b] == BANK_FULL) ||
                       (bank_state_q[b] == BANK_DRAINING);
    end
  end

  // ---------------------------------------------------------------------------
  // Bank FSMs, write pointer and read address sequencer.
  // The write side changes a bank only while that bank is EMPTY/FILLING, and
  // the read side only while it is FULL/DRAINING. So both sides can update
  // bank_state_q in the same cycle and never collide on one bank.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bank_state_q[0] <= BANK_EMPTY;
      bank_state_q[1] <= BANK_EMPTY;
      bank_lines_q[0] <= LW'(STRIP_LINES);
      bank_lines_q[1] <= LW'(STRIP_LINES);
      cfg_valid_q     <= 1'b0;
      wpl_q           <= 8'd1;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      wr_col_q        <= '0;
      wr_line_q       <= '0;
      wr_addr_q       <= '0;
      rd_col_q        <= '0;
      rd_row_q        <= '0;
      rd_addr_q       <= '0;
      rd_col_addr_q   <= '0;
      rd_lines_q      <= LW'(STRIP_LINES);
      rd_issue_done_q <= 1'b0;
    end else begin
      // ---- write side ----
      if (frame_ok) begin
        cfg_valid_q <= 1'b1;
        wpl_q       <= cfg_wpl_eff;
        wr_bank_q   <= 1'b0;
        rd_bank_q   <= 1'b0;
        wr_col_q    <= '0;
        wr_line_q   <= '0;
        wr_addr_q   <= '0;
      end else if (flush_hit) begin
        bank_state_q[wr_bank_q] <= BANK_FULL;
        bank_lines_q[wr_bank_q] <= LW'(wr_line_q);
        wr_bank_q               <= ~wr_bank_q;
        wr_col_q                <= '0;
        wr_line_q               <= '0;
        wr_addr_q               <= bank_base(~wr_bank_q);
      end else if (wr_fire) begin
        if (bank_state_q[wr_bank_q] == BANK_EMPTY) begin
          bank_state_q[wr_bank_q] <= BANK_FILLING;
        end
        if (wr_strip_end) begin
          bank_state_q[wr_bank_q] <= BANK_FULL;
          bank_lines_q[wr_bank_q] <= LW'(STRIP_LINES);
          wr_bank_q               <= ~wr_bank_q;
          wr_col_q                <= '0;
          wr_line_q               <= '0;
          wr_addr_q               <= bank_base(~wr_bank_q);
        end else if (wr_line_end) begin
          // Raster order is contiguous inside a bank, so the address just counts.
          wr_col_q  <= '0;
          wr_line_q <= wr_line_q + RW'(1);
          wr_addr_q <= wr_addr_q + 12'd1;
        end else begin
          wr_col_q  <= wr_col_q + 8'd1;
          wr_addr_q <= wr_addr_q + 12'd1;
        end
      end

      // ---- read side ----
      if (bank_state_q[rd_bank_q] == BANK_FULL) begin
        bank_state_q[rd_bank_q] <= BANK_DRAINING;
        rd_col_q        <= '0;
        rd_row_q        <= '0;
        rd_addr_q       <= bank_base(rd_bank_q);
        rd_col_addr_q   <= bank_base(rd_bank_q);
        rd_lines_q      <= bank_lines_q[rd_bank_q];
        rd_issue_done_q <= 1'b0;
      end else if (bank_state_q[rd_bank_q] == BANK_DRAINING) begin
        if (ram_rd_en_o) begin
          if (rd_row_last) begin
            // Next column: address restarts at base + col + 1. This avoids a
            // multiplier.
            rd_row_q      <= '0;
            rd_col_q      <= rd_col_q + 8'd1;
            rd_col_addr_q <= rd_col_addr_q + 12'd1;
            rd_addr_q     <= rd_col_addr_q + 12'd1;
            if (rd_strip_last) begin
              rd_issue_done_q <= 1'b1;
            end
          end else begin
            rd_row_q <= rd_row_q + RW'(1);
            if (rd_row_step) begin
              rd_addr_q <= rd_addr_q + {4'd0, wpl_q};
            end
          end
        end
        if (pop && out_strip_last_o) begin
          bank_state_q[rd_bank_q] <= BANK_EMPTY;
          rd_bank_q               <= ~rd_bank_q;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output skid FIFO control. Reset discards the read in flight and the
  // queued words.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight_q    <= 1'b0;
      inflight_rl_q <= 1'b0;
      inflight_sl_q <= 1'b0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      inflight_q    <= ram_rd_en_o;
      inflight_rl_q <= rd_row_last;
      inflight_sl_q <= rd_strip_last;
      if (inflight_q) begin
        fifo_wr_ptr_q <= ~fifo_wr_ptr_q;
      end
      if (pop) begin
        fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      end
      fifo_cnt_q <= occ;
    end
  end

  // NOTE: the FIFO storage has no reset. fifo_cnt_q decides which entries are
  // valid, and the outputs are gated by out_valid_o.
  always_ff @(posedge clk) begin
    if (inflight_q) begin
      fifo_data_q[fifo_wr_ptr_q] <= ram_rd_data_i;
      fifo_rl_q[fifo_wr_ptr_q]   <= inflight_rl_q;
      fifo_sl_q[fifo_wr_ptr_q]   <= inflight_sl_q;
    end
  end

endmodule

// File: tb/tb_jpeg_line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jpeg_line_buffer_ctrl
//
// The stimulus side drives random pixel words and frame and flush pulses.
// Whenever a strip finishes, the reference model turns the words of that strip
// into the expected block-column-order sequence and queues it. A monitor pops
// that queue whenever the DUT hands over an output word. An EBR model stands in
// for the dual-port RAM.
// -----------------------------------------------------------------------------
module tb_jpeg_line_buffer_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        frame_start_i;
  logic [7:0]  cfg_wpl_i;
`ifdef LB_FLUSH_EN
  logic        flush_i;
`endif
  logic        in_valid_i, in_ready_o;
  logic [63:0] in_data_i;
  logic        out_valid_o, out_ready_i;
  logic [63:0] out_data_o;
  logic        out_row_last_o, out_strip_last_o;
  logic        ram_wr_en_o, ram_rd_en_o;
  logic [7:0]  ram_ben_o;
  logic [11:0] ram_wr_addr_o, ram_rd_addr_o;
  logic [63:0] ram_wr_data_o, ram_rd_data_i;
  logic [1:0]  bank_full_o;

  always #5 clk = ~clk;

  jpeg_line_buffer_ctrl dut (
    .clk              (clk),
    .resetn           (resetn),
    .frame_start_i    (frame_start_i),
    .cfg_wpl_i        (cfg_wpl_i),
`ifdef LB_FLUSH_EN
    .flush_i          (flush_i),
`endif
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_data_i        (in_data_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_data_o       (out_data_o),
    .out_row_last_o   (out_row_last_o),
    .out_strip_last_o (out_strip_last_o),
    .ram_wr_en_o      (ram_wr_en_o),
    .ram_ben_o        (ram_ben_o),
    .ram_wr_addr_o    (ram_wr_addr_o),
    .ram_wr_data_o    (ram_wr_data_o),
    .ram_rd_en_o      (ram_rd_en_o),
    .ram_rd_addr_o    (ram_rd_addr_o),
    .ram_rd_data_i    (ram_rd_data_i),
    .bank_full_o      (bank_full_o)
  );

  // EBR model: registered read, one cycle latency.
  logic [63:0] ebr [0:2879];
  always @(posedge clk) begin
    if (ram_wr_en_o && ram_wr_addr_o < 12'd2880) ebr[ram_wr_addr_o] <= ram_wr_data_o;
    if (ram_rd_en_o && ram_rd_addr_o < 12'd2880) ram_rd_data_i <= ebr[ram_rd_addr_o];
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [63:0] d;
    logic        rl;
    logic        sl;
  } word_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wpl_m = 1;
  int          parity_m = 0;      // which bank the model is filling
  logic [63:0] cur_q [$];         // words of the strip being filled
  word_t       exp_q [$];
  word_t       log_q [$];         // everything popped, for explicit checks
  int          issued = 0, popped = 0, max_outst = 0;
  int          max_wr_addr = 0;
  int          gaps = 0;
  bit          gap_en = 0;
  bit          prev_mid = 0;
  int          mode = 1;          // 0 ready low, 1 high, 2 random, 3 toggle

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Block-column order: for every column, rows 0..7. Rows at or past k repeat
  // line k-1.
  function automatic void gen_strip(input int k);
    for (int c = 0; c < wpl_m; c++) begin
      for (int r = 0; r < 8; r++) begin
        word_t w;
        w.d  = cur_q[((r < k) ? r : k - 1) * wpl_m + c];
        w.rl = (r == 7);
        w.sl = (r == 7) && (c == wpl_m - 1);
        exp_q.push_back(w);
      end
    end
    cur_q.delete();
    parity_m ^= 1;
  endfunction

  // Monitor: samples on the falling edge, so it sees what the next rising
  // edge will take.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (in_valid_i && in_ready_o) begin
          check("wr_en", ram_wr_en_o, 1);
          check("wr_addr", ram_wr_addr_o, 64'(parity_m * 1440 + cur_q.size()));
          check("wr_data", ram_wr_data_o, in_data_i);
          if (int'(ram_wr_addr_o) > max_wr_addr) max_wr_addr = int'(ram_wr_addr_o);
          cur_q.push_back(in_data_i);
          if (cur_q.size() == 8 * wpl_m) gen_strip(8);
        end
        if (gap_en && prev_mid && !out_valid_o) gaps++;
        prev_mid = out_valid_o && out_ready_i && !out_strip_last_o;
        if (ram_rd_en_o) issued++;
        if (out_valid_o && out_ready_i) begin
          word_t a;
          popped++;
          a.d = out_data_o; a.rl = out_row_last_o; a.sl = out_strip_last_o;
          log_q.push_back(a);
          if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            word_t e;
            e = exp_q.pop_front();
            check("out_data", out_data_o, e.d);
            check("out_flags", {out_row_last_o, out_strip_last_o}, {e.rl, e.sl});
          end
        end
        if (issued - popped > max_outst) max_outst = issued - popped;
      end
    end
  end

  // Downstream ready pattern.
  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready_i = 1'b0;
        1:       out_ready_i = 1'b1;
        2:       out_ready_i = 1'($urandom_range(0, 1));
        default: out_ready_i = ~out_ready_i;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d, input bit gaps_on);
    bit acc;
    acc = 0;
    if (gaps_on) repeat ($urandom_range(0, 2)) tick();
    in_valid_i = 1'b1;
    in_data_i  = d;
    for (int t = 0; t < 4000 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready_o;
      tick();
    end
    in_valid_i = 1'b0;
    if (!acc) check("in_accept_timeout", 0, 1);
  endtask

  task automatic frame(input int cfg);
    bit acc;
    acc = (exp_q.size() == 0) && (cur_q.size() == 0);
    frame_start_i = 1'b1;
    cfg_wpl_i     = 8'(cfg);
    tick();
    frame_start_i = 1'b0;
    if (acc) begin
      wpl_m    = (cfg == 0) ? 1 : ((cfg > 180) ? 180 : cfg);
      parity_m = 0;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int t = 0; t < 20000 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bank_full_o == 2'b00 && !out_valid_o) done = 1;
    end
    check("idle_timeout", done, 1);
    tick();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Watchdog: fires only if the run hangs.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cnt;
    logic [63:0] abc [3];
    resetn = 1'b0; frame_start_i = 1'b0; cfg_wpl_i = 8'd0;
    in_valid_i = 1'b0; in_data_i = 64'd0;
`ifdef LB_FLUSH_EN
    flush_i = 1'b0;
`endif
    #22;
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_wr_en", ram_wr_en_o, 0);
    check("rst_rd_en", ram_rd_en_o, 0);
    check("rst_ben", ram_ben_o, 8'hFF);
    check("rst_bank_full", bank_full_o, 0);
    check("rst_wr_addr", ram_wr_addr_o, 0);
    check("rst_out_data", out_data_o, 0);
    tick();
    resetn = 1'b1;
    tick();

    // 1: wpl=2, words 0..15.
    frame(2); mode = 1; log_q.delete();
    for (int i = 0; i < 16; i++) send_word(64'(i), 0);
    wait_idle();
    check("t1_count", log_q.size(), 16);
    if (log_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("t1_data%0d", i), log_q[i].d, 64'((i < 8) ? 2 * i : 2 * (i - 8) + 1));
        check($sformatf("t1_flags%0d", i), {log_q[i].rl, log_q[i].sl},
              {1'(i == 7 || i == 15), 1'(i == 15)});
      end
    end

    // 2: wpl=180, continuous input and output, two full banks.
    frame(180); mode = 1; log_q.delete(); max_wr_addr = 0; gaps = 0; gap_en = 1;
    for (int i = 0; i < 2880; i++) send_word(rnd64(), 0);
    wait_idle();
    gap_en = 0;
    check("t2_gaps", gaps, 0);
    check("t2_max_wr_addr", max_wr_addr, 2879);
    cnt = 0;
    foreach (log_q[i]) if (log_q[i].sl) cnt++;
    check("t2_words", log_q.size(), 2880);
    check("t2_strips", cnt, 2);

    // 3: output stalled, so both banks fill, then input backpressure.
    frame(2); mode = 0;
    for (int i = 0; i < 32; i++) send_word(rnd64(), 1);
    in_valid_i = 1'b1; in_data_i = rnd64();
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready_o) cnt++;
      tick();
    end
    in_valid_i = 1'b0;
    check("t3_bank_full", bank_full_o, 2'b11);
    check("t3_ready_cycles", cnt, 0);
    mode = 2;
    send_word(in_data_i, 0);
    for (int i = 0; i < 15; i++) send_word(rnd64(), 1);
    wait_idle();

    // 4: toggling ready, random wpl, ignored frame_start mid-strip.
    issued = 0; popped = 0; max_outst = 0;
    frame($urandom_range(1, 12)); mode = 3;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8 * wpl_m; i++) begin
        send_word(rnd64(), 1);
        if (s == 0 && i == 3) frame(wpl_m + 5);
      end
    end
    wait_idle();
    check("t4_max_outstanding_le2", 64'(max_outst <= 2), 1);

    // 5: cfg 0 behaves as one word per line.
    frame(0); mode = 2;
    for (int i = 0; i < 16; i++) send_word(rnd64(), 1);
    wait_idle();

    // 6: reset in mid-drain with a read in flight, then a clean restart.
    frame(4); mode = 1;
    for (int i = 0; i < 32; i++) send_word(rnd64(), 0);
    cnt = 0;
    for (int t = 0; t < 200 && cnt == 0; t++) begin
      @(negedge clk);
      if (ram_rd_en_o) cnt = 1;
    end
    check("t6_read_seen", cnt, 1);
    @(posedge clk); #1;
    resetn = 1'b0;
    exp_q.delete(); cur_q.delete(); issued = 0; popped = 0;
    @(negedge clk);
    check("t6_out_valid_after_rst", out_valid_o, 0);
    check("t6_rd_en_after_rst", ram_rd_en_o, 0);
    check("t6_bank_full_after_rst", bank_full_o, 0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    frame(2); log_q.delete();
    for (int i = 0; i < 16; i++) send_word(64'(i + 100), 0);
    wait_idle();
    check("t6_restart_count", log_q.size(), 16);
    if (log_q.size() == 16) check("t6_restart_first", log_q[0].d, 100);

`ifdef LB_FLUSH_EN
    // 7: flush after three one-word lines gives bottom replication.
    frame(1); mode = 1; log_q.delete();
    for (int i = 0; i < 3; i++) begin
      abc[i] = rnd64();
      send_word(abc[i], 0);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    begin
      int k;
      k = cur_q.size() / wpl_m;
      if (k >= 1) begin
        while (cur_q.size() > k * wpl_m) void'(cur_q.pop_back());
        gen_strip(k);
      end
    end
    wait_idle();
    check("t7_count", log_q.size(), 8);
    if (log_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t7_data%0d", i), log_q[i].d, abc[(i < 3) ? i : 2]);
        check($sformatf("t7_flags%0d", i), {log_q[i].rl, log_q[i].sl},
              {1'(i == 7), 1'(i == 7)});
      end
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick(); tick();
    check("t7_flush_empty_noop", bank_full_o, 0);
`endif

    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
